// File: rtl/spi_mem_ctrl_pkg.sv
// spi_mem_ctrl shared types: command opcodes and controller states.
// Used by spi_mem_ctrl and spi_mem_addr_ptr.
package spi_mem_ctrl_pkg;

  localparam int OP_W    = 2;
  localparam int STATE_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_SET_WADDR = 2'b00,
    OP_WR_DATA   = 2'b01,
    OP_SET_RADDR = 2'b10,
    OP_RD_BURST  = 2'b11
  } op_e;

  typedef enum logic [STATE_W-1:0] {
    IDLE     = 3'd0,
    WRITE    = 3'd1,
    RD_ISSUE = 3'd2,
    RD_WAIT  = 3'd3,
    RD_RESP  = 3'd4
  } state_e;

endpackage

// File: rtl/spi_mem_addr_ptr.sv
// spi_mem_addr_ptr: loadable RAM address pointer.
// Increments wrap from the last RAM word back to 0.
module spi_mem_addr_ptr
  import spi_mem_ctrl_pkg::*;
#(
  parameter int MEM_DEPTH = 1024,
  parameter int ADDR_SIZE = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [ADDR_SIZE-1:0] load_val,
  input  logic                 inc,
  output logic [ADDR_SIZE-1:0] ptr
);

  localparam logic [ADDR_SIZE-1:0] LAST =
    ADDR_SIZE'(MEM_DEPTH - 1);

  // load wins over increment; increment wraps
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
    end else if (load) begin
      ptr <= load_val;
    end else if (inc) begin
      if (ptr == LAST) ptr <= '0;
      else             ptr <= ptr + 1'b1;
    end
  end

endmodule

// File: rtl/spi_mem_ctrl.sv
// spi_mem_ctrl: SPI command side driving a registered 16-bit RAM.
// Define SPI_MEM_CTRL_AUTO_INC_EN for pointer auto-increment.
module spi_mem_ctrl
  import spi_mem_ctrl_pkg::*;
#(
  parameter int MEM_WIDTH = 16,
  parameter int MEM_DEPTH = 1024,
  parameter int ADDR_SIZE = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [MEM_WIDTH-1:0] cmd_data,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [MEM_WIDTH-1:0] rsp_data,
  output logic [MEM_WIDTH-1:0] mem_din,
  output logic [ADDR_SIZE-1:0] mem_addr_wr,
  output logic [ADDR_SIZE-1:0] mem_addr_rd,
  output logic                 mem_wr_en,
  output logic                 mem_rd_en,
  output logic                 mem_blk_select,
  input  logic [MEM_WIDTH-1:0] mem_dout,
  output logic                 busy
);

`ifdef SPI_MEM_CTRL_AUTO_INC_EN
  localparam logic AUTO_INC = 1'b1;
`else
  localparam logic AUTO_INC = 1'b0;
`endif

  state_e               state;
  op_e                  op;
  logic                 accept;
  logic [ADDR_SIZE-1:0] cmd_addr;
  logic [ADDR_SIZE-1:0] remaining;
  logic [ADDR_SIZE-1:0] wr_ptr;
  logic [ADDR_SIZE-1:0] rd_ptr;
  logic                 wr_load;
  logic                 wr_inc;
  logic                 rd_load;
  logic                 rd_inc;

  assign op       = op_e'(cmd_op);
  assign accept   = cmd_valid && cmd_ready;
  assign cmd_addr = cmd_data[ADDR_SIZE-1:0];

  assign wr_load = accept && (op == OP_SET_WADDR);
  assign rd_load = accept && (op == OP_SET_RADDR);
  assign wr_inc  = AUTO_INC && (state == WRITE);
  assign rd_inc  = AUTO_INC && (state == RD_ISSUE);

  assign mem_addr_wr = wr_ptr;
  assign mem_addr_rd = rd_ptr;

  spi_mem_addr_ptr #(
    .MEM_DEPTH (MEM_DEPTH),
    .ADDR_SIZE (ADDR_SIZE)
  ) u_wr_ptr (
    .clk      (clk),
    .rst      (rst),
    .load     (wr_load),
    .load_val (cmd_addr),
    .inc      (wr_inc),
    .ptr      (wr_ptr)
  );

  spi_mem_addr_ptr #(
    .MEM_DEPTH (MEM_DEPTH),
    .ADDR_SIZE (ADDR_SIZE)
  ) u_rd_ptr (
    .clk      (clk),
    .rst      (rst),
    .load     (rd_load),
    .load_val (cmd_addr),
    .inc      (rd_inc),
    .ptr      (rd_ptr)
  );

  // controller FSM; strobes are set on entry to the cycle they cover
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      cmd_ready      <= 1'b0;
      busy           <= 1'b0;
      rsp_valid      <= 1'b0;
      rsp_data       <= '0;
      mem_din        <= '0;
      mem_wr_en      <= 1'b0;
      mem_rd_en      <= 1'b0;
      mem_blk_select <= 1'b0;
      remaining      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (accept) begin
            unique case (op)
              OP_WR_DATA: begin
                mem_din        <= cmd_data;
                mem_wr_en      <= 1'b1;
                mem_blk_select <= 1'b1;
                cmd_ready      <= 1'b0;
                busy           <= 1'b1;
                state          <= WRITE;
              end
              OP_RD_BURST: begin
                remaining      <= cmd_addr;
                mem_rd_en      <= 1'b1;
                mem_blk_select <= 1'b1;
                cmd_ready      <= 1'b0;
                busy           <= 1'b1;
                state          <= RD_ISSUE;
              end
              default: ;
            endcase
          end
        end
        WRITE: begin
          mem_wr_en      <= 1'b0;
          mem_blk_select <= 1'b0;
          cmd_ready      <= 1'b1;
          busy           <= 1'b0;
          state          <= IDLE;
        end
        RD_ISSUE: begin
          mem_rd_en      <= 1'b0;
          mem_blk_select <= 1'b0;
          state          <= RD_WAIT;
        end
        RD_WAIT: begin
          rsp_data  <= mem_dout;
          rsp_valid <= 1'b1;
          state     <= RD_RESP;
        end
        RD_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            if (remaining == '0) begin
              cmd_ready <= 1'b1;
              busy      <= 1'b0;
              state     <= IDLE;
            end else begin
              remaining      <= remaining - 1'b1;
              mem_rd_en      <= 1'b1;
              mem_blk_select <= 1'b1;
              state          <= RD_ISSUE;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_mem_ctrl.sv
// tb_spi_mem_ctrl: spi_mem_ctrl with a registered RAM model.
// Expected traffic comes from a command-level memory model.
module tb_spi_mem_ctrl;
  import spi_mem_ctrl_pkg::*;

  localparam int W  = 16;
  localparam int AW = 10;
  localparam int D  = 1024;

`ifdef SPI_MEM_CTRL_AUTO_INC_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [W-1:0]  cmd_data;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [W-1:0]  rsp_data;
  logic [W-1:0]  mem_din;
  logic [AW-1:0] mem_addr_wr;
  logic [AW-1:0] mem_addr_rd;
  logic          mem_wr_en;
  logic          mem_rd_en;
  logic          mem_blk_select;
  logic [W-1:0]  mem_dout;
  logic          busy;

  spi_mem_ctrl #(
    .MEM_WIDTH (W),
    .MEM_DEPTH (D),
    .ADDR_SIZE (AW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_op         (cmd_op),
    .cmd_data       (cmd_data),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_data       (rsp_data),
    .mem_din        (mem_din),
    .mem_addr_wr    (mem_addr_wr),
    .mem_addr_rd    (mem_addr_rd),
    .mem_wr_en      (mem_wr_en),
    .mem_rd_en      (mem_rd_en),
    .mem_blk_select (mem_blk_select),
    .mem_dout       (mem_dout),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM with registered read port
  logic [W-1:0] ram [D];
  always @(posedge clk) begin
    if (mem_wr_en) ram[mem_addr_wr] <= mem_din;
    if (mem_rd_en) mem_dout <= ram[mem_addr_rd];
  end

  int n_cmp;
  int n_err;
  int rd_cnt;
  logic [W-1:0] first_word;

  function automatic void chk(string name,
                              logic [31:0] got,
                              logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, got, exp);
    end
  endfunction

  // command-level model
  logic [W-1:0] ref_mem [D];
  int           wp;
  int           rp;
  logic [W-1:0] rsp_q [$];
  int           ra_q  [$];
  int           wa_q  [$];
  logic [W-1:0] wd_q  [$];

  function automatic void model_cmd(logic [1:0] op,
                                    logic [W-1:0] d);
    int a;
    a = int'(d) % D;
    case (op)
      OP_SET_WADDR: wp = a;
      OP_SET_RADDR: rp = a;
      OP_WR_DATA: begin
        ref_mem[wp] = d;
        wa_q.push_back(wp);
        wd_q.push_back(d);
        if (AUTO) wp = (wp + 1) % D;
      end
      default: begin
        for (int i = 0; i <= a; i++) begin
          rsp_q.push_back(ref_mem[rp]);
          ra_q.push_back(rp);
          if (AUTO) rp = (rp + 1) % D;
        end
      end
    endcase
  endfunction

  function automatic void model_reset();
    wp = 0;
    rp = 0;
    rsp_q.delete();
    ra_q.delete();
    wa_q.delete();
    wd_q.delete();
  endfunction

  // RAM-pin monitor
  always @(negedge clk) begin
    if (rst) begin
      chk("blk_sel", mem_blk_select,
          mem_wr_en | mem_rd_en);
      chk("wr_rd_excl", mem_wr_en & mem_rd_en, 0);
      if (mem_wr_en) begin
        chk("wr_expected", wa_q.size() != 0, 1);
        if (wa_q.size() != 0) begin
          chk("wr_addr", mem_addr_wr, wa_q.pop_front());
          chk("wr_data", mem_din, wd_q.pop_front());
        end
      end
      if (mem_rd_en) begin
        rd_cnt++;
        chk("rd_expected", ra_q.size() != 0, 1);
        if (ra_q.size() != 0)
          chk("rd_addr", mem_addr_rd, ra_q.pop_front());
      end
    end
  end

  task automatic send_cmd(input logic [1:0] op,
                          input logic [W-1:0] d);
    int t;
    t = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    while (!cmd_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!cmd_ready) begin
      chk("cmd_ready_timeout", cmd_ready, 1);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    model_cmd(op, d);
  endtask

  task automatic collect(input int len, input int stall);
    logic [W-1:0] got;
    logic [W-1:0] exp;
    int t;
    int rc;
    @(posedge clk); #1;
    chk("lat_edge1", rsp_valid, 0);
    @(posedge clk); #1;
    chk("lat_edge2", rsp_valid, 1);
    for (int w = 0; w <= len; w++) begin
      t = 0;
      @(negedge clk);
      while (!rsp_valid && t < 20) begin
        @(negedge clk);
        t++;
      end
      chk("rsp_timeout", rsp_valid, 1);
      if (!rsp_valid) return;
      got = rsp_data;
      rc  = rd_cnt;
      for (int s = 0; s < stall; s++) begin
        @(negedge clk);
        chk("stall_data", rsp_data, got);
        chk("stall_valid", rsp_valid, 1);
        chk("stall_cmd_ready", cmd_ready, 0);
      end
      if (stall > 0) chk("stall_no_rd", rd_cnt, rc);
      chk("rsp_expected", rsp_q.size() != 0, 1);
      exp = '0;
      if (rsp_q.size() != 0) exp = rsp_q.pop_front();
      chk("rsp_data", got, exp);
      if (w == 0) first_word = got;
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_cmd_ready"}, cmd_ready, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_data"}, rsp_data, 0);
    chk({tag, "_mem_din"}, mem_din, 0);
    chk({tag, "_addr_wr"}, mem_addr_wr, 0);
    chk({tag, "_addr_rd"}, mem_addr_rd, 0);
    chk({tag, "_wr_en"}, mem_wr_en, 0);
    chk({tag, "_rd_en"}, mem_rd_en, 0);
    chk({tag, "_blk_sel"}, mem_blk_select, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] data;
    int           stall;
    logic         busy;
  } vec_t;

  vec_t tbl [13];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]   op;
    logic [W-1:0] d;
    int           len;
    int           t;

    tbl[0]  = '{OP_SET_WADDR, 16'h0005, 0, 1'b0};
    tbl[1]  = '{OP_WR_DATA,   16'hA5A5, 0, 1'b1};
    tbl[2]  = '{OP_WR_DATA,   16'h1234, 0, 1'b1};
    tbl[3]  = '{OP_SET_RADDR, 16'h0005, 0, 1'b0};
    tbl[4]  = '{OP_RD_BURST,  16'h0001, 0, 1'b1};
    tbl[5]  = '{OP_SET_RADDR, 16'h0005, 0, 1'b0};
    tbl[6]  = '{OP_RD_BURST,  16'h0002, 5, 1'b1};
    tbl[7]  = '{OP_SET_WADDR, 16'h03FF, 0, 1'b0};
    tbl[8]  = '{OP_WR_DATA,   16'hBEEF, 0, 1'b1};
    tbl[9]  = '{OP_SET_WADDR, 16'h0000, 0, 1'b0};
    tbl[10] = '{OP_WR_DATA,   16'hCAFE, 0, 1'b1};
    tbl[11] = '{OP_SET_RADDR, 16'h03FF, 0, 1'b0};
    tbl[12] = '{OP_RD_BURST,  16'h0001, 0, 1'b1};

    n_cmp      = 0;
    n_err      = 0;
    rd_cnt     = 0;
    first_word = '0;
    for (int i = 0; i < D; i++) begin
      ram[i]     = '0;
      ref_mem[i] = '0;
    end
    model_reset();
    rst       = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_data  = '0;
    rsp_ready = 1'b0;

    #12;
    chk_all_zero("reset");
    @(posedge clk); #2;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_reset", cmd_ready, 1);

    for (int i = 0; i < 13; i++) begin
      send_cmd(tbl[i].op, tbl[i].data);
      chk("vec_busy", busy, tbl[i].busy);
      chk("vec_cmd_ready", cmd_ready, !tbl[i].busy);
      if (tbl[i].op == OP_RD_BURST)
        collect(int'(tbl[i].data) % D, tbl[i].stall);
    end
    chk("wrap_first_word", first_word, 16'hBEEF);

    send_cmd(OP_SET_WADDR, 16'h0005);
    send_cmd(OP_WR_DATA, 16'hA5A5);
    send_cmd(OP_SET_RADDR, 16'h0005);
    send_cmd(OP_RD_BURST, 16'h0002);
    collect(2, 0);
`ifndef SPI_MEM_CTRL_AUTO_INC_EN
    chk("fixed_first_word", first_word, 16'hA5A5);
    chk("fixed_addr_rd", mem_addr_rd, 10'h005);
`endif

    send_cmd(OP_SET_RADDR, 16'h0005);
    send_cmd(OP_RD_BURST, 16'h0003);
    t = 0;
    @(negedge clk);
    while (!rsp_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("midburst_valid", rsp_valid, 1);
    @(posedge clk); #2;
    rst = 1'b0;
    model_reset();
    #1;
    chk_all_zero("midburst");
    @(posedge clk); #2;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midburst_ready", cmd_ready, 1);
    chk("midburst_busy", busy, 0);

    repeat (80) begin
      op = 2'($urandom_range(0, 3));
      len = 0;
      case (op)
        OP_WR_DATA: d = 16'($urandom);
        OP_RD_BURST: begin
          len = $urandom_range(0, 3);
          d = 16'(($urandom_range(0, 63) << 10) | len);
        end
        default: d = 16'($urandom);
      endcase
      send_cmd(op, d);
      chk("rand_busy", busy,
          op == OP_WR_DATA || op == OP_RD_BURST);
      if (op == OP_RD_BURST)
        collect(len, $urandom_range(0, 2));
    end

    send_cmd(OP_SET_RADDR, 16'h0000);
    send_cmd(OP_RD_BURST, 16'hFFFF);
    collect(D - 1, 0);
    @(negedge clk);
    chk("full_burst_idle", busy, 0);

    repeat (3) @(negedge clk);
    chk("drain_rsp", rsp_q.size(), 0);
    chk("drain_rd", ra_q.size(), 0);
    chk("drain_wr", wa_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
